// File: rtl/csa_4_bit.sv
// 4-bit carry-skip adder with registered outputs.
// Computes a + b + c_in through a per-bit ripple chain, with a group-propagate
// skip mux on the carry out. Registered sum, carry-out and group propagate
// give one cycle of latency. The p and c_out outputs let several instances be
// cascaded into wider skip adders.
module csa_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       p
);

    // Per-bit propagate/generate terms
    logic [3:0] prop;
    logic [3:0] gen;

    // Ripple carries: carry[0] is c_in, carry[4] is the rippled carry out
    logic [4:0] carry;

    // Combinational results feeding the output registers
    logic [3:0] sum_d;
    logic       grp_p;
    logic       c_out_d;

    // Output registers
    logic [3:0] sum_q;
    logic       c_out_q;
    logic       p_q;

    // Per-bit propagate and generate
    always_comb begin
        prop = a ^ b;
        gen  = a & b;
    end

    // Ripple chain producing the sum bits and the rippled carry out
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
            sum_d[i]   = prop[i] ^ carry[i];
        end
    end

    // Skip mux: when every bit propagates, c_in bypasses the ripple chain.
    // It is functionally identical to carry[4], but it is kept as its own
    // structure so that a wider cascade sees a short c_in-to-c_out path.
    always_comb begin
        grp_p   = &prop;
        c_out_d = grp_p ? c_in : carry[4];
    end

    // Output registers: capture every cycle, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 4'h0;
            c_out_q <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            p_q     <= grp_p;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign p     = p_q;

endmodule

// File: tb/tb_csa_4_bit.sv
// Self-checking bench for csa_4_bit: directed steps plus an exhaustive sweep,
// with expected results queued at drive time and checked one cycle later.
module tb_csa_4_bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       p;

    // Expected {c_out, sum, p}
    logic [5:0] sb[$];
    logic [5:0] last_exp;
    logic       last_valid;

    int vectors;
    int errs;

    csa_4_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed c_out/sum/p=%b_%h_%b expected %b_%h_%b",
                   tag, obs[5], obs[4:1], obs[0], exp[5], exp[4:1], exp[0]);
        end
    endtask

    // Reference result built from plain arithmetic
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mc);
        logic [4:0] total;
        logic       prop_all;
        total    = {1'b0, ma} + {1'b0, mb} + {4'b0, mc};
        prop_all = ((ma ^ mb) == 4'hF);
        return {total, prop_all};
    endfunction

    // Drive one vector, check the outputs still hold the previous result
    // before the edge, then pop and compare after the edge.
    task automatic step(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [5:0] exp);
        logic [5:0] want;
        a    = va;
        b    = vb;
        c_in = vc;
        sb.push_back(exp);
        #1;
        if (last_valid) check({tag, "_hold"}, {c_out, sum, p}, last_exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL %s: scoreboard empty, observed %b_%h_%b", tag, c_out, sum, p);
        end else begin
            want = sb.pop_front();
            check(tag, {c_out, sum, p}, want);
            last_exp   = want;
            last_valid = 1'b1;
        end
    endtask

    initial begin
        vectors    = 0;
        errs       = 0;
        last_valid = 1'b0;
        last_exp   = '0;

        // Reset asserted with max operands applied, no clock edge yet
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        c_in  = 1'b1;
        #1;
        check("reset_no_edge", {c_out, sum, p}, 6'b0_0000_0);

        // Release between edges; first capture on the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        step("first_capture", 4'hF, 4'hF, 1'b1, {1'b1, 4'hF, 1'b0});

        // Zero and max operands
        step("all_zero", 4'h0, 4'h0, 1'b0, {1'b0, 4'h0, 1'b0});
        step("max_gen", 4'hF, 4'hF, 1'b0, {1'b1, 4'hE, 1'b0});

        // Skip path: all bits propagate
        step("skip_cin1", 4'hF, 4'h0, 1'b1, {1'b1, 4'h0, 1'b1});
        step("skip_cin0", 4'h5, 4'hA, 1'b0, {1'b0, 4'hF, 1'b1});

        // Latency sequence, inputs changing every cycle
        step("lat_0", 4'h3, 4'h4, 1'b0, {5'd7, 1'b0});
        step("lat_1", 4'h7, 4'h9, 1'b1, {5'd17, 1'b0});
        step("lat_2", 4'h8, 4'h8, 1'b0, {5'd16, 1'b0});

        // Mid-operation reset while outputs are nonzero
        check("pre_midreset", {c_out, sum, p}, {5'd16, 1'b0});
        rst_n = 1'b0;
        #1;
        check("midreset_async", {c_out, sum, p}, 6'b0);
        @(posedge clk);
        #1;
        check("midreset_hold", {c_out, sum, p}, 6'b0);
        last_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 4'h9, 4'h6, 1'b1, {1'b1, 4'h0, 1'b1});

        // Exhaustive sweep of all 512 input combinations
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ec;
            ea = i[8:5];
            eb = i[4:1];
            ec = i[0];
            step("exhaustive", ea, eb, ec, model(ea, eb, ec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/csa_4_bit.md
Name: csa_4_bit

Overview:
- 4-bit carry-skip adder: adds `a` + `b` + `c_in`.
- Outputs: 4-bit `sum`, carry-out `c_out`, and group propagate `p`.
- `p` and `c_out` let several instances be cascaded into wider skip adders.
- Combinational datapath with all outputs registered: one clock cycle latency, asynchronous active-low reset.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `a` input 4: addend A, unsigned.
- `b` input 4: addend B, unsigned.
- `c_in` input 1: carry into bit 0.
- `sum` output 4: registered (`a` + `b` + `c_in`) mod 16.
- `c_out` output 1: registered carry out of bit 3.
- `p` output 1: registered group propagate, AND over i of (`a[i]` XOR `b[i]`).

Behaviour:
- Per-bit terms:
  - propagate `pi` = `a[i]` XOR `b[i]`
  - generate `gi` = `a[i]` AND `b[i]`
- Ripple chain:
  - `c0` = `c_in`
  - `c(i+1)` = `gi` OR (`pi` AND `ci`)
  - `sum[i]` = `pi` XOR `ci`
- Skip path:
  - group `P` = `p0` & `p1` & `p2` & `p3`
  - `c_out_next` = `P` ? `c_in` : `c4_ripple`
  - The skip mux is mandatory as a distinct structure. It must be functionally identical to `c4_ripple` for all inputs.
- Arithmetic: {`c_out`, `sum`} equals the 5-bit unsigned result of `a` + `b` + `c_in`, range 0..31. No signed interpretation and no overflow flag.
- Timing:
  - On each rising `clk` edge with `rst_n` high, `sum`, `c_out` and `p` capture the combinational results of the `a`/`b`/`c_in` values present before the edge.
  - Latency is exactly 1 cycle. There is no enable: the registers update every cycle.
- Reset:
  - `rst_n` low forces `sum`=4'h0, `c_out`=0, `p`=0 immediately, independent of `clk`.
  - Outputs hold these values while `rst_n` stays low.
  - The first capture happens on the first rising edge after `rst_n` deasserts.
- Reset mid-operation: any result in flight is discarded. There is no residual state beyond the output registers.
- Boundary cases:
  - `a`=`b`=4'hF: `P`=0, carry comes from the generate chain.
  - `a` XOR `b` = 4'hF: `P`=1, so `c_out` equals `c_in` via the skip path. `sum` = ~`c_in` replicated across all 4 bits.
  - All-zero operands: `sum`=0, `c_out`=0, `p`=0.
- Inputs are sampled only at clock edges. Glitches between edges have no effect on outputs.
- X/Z on inputs is not handled specially. Benches drive known values only.

Test Plan:
- Reset: `rst_n`=0 with `a`=4'hF, `b`=4'hF, `c_in`=1 → `sum`=0, `c_out`=0, `p`=0 with no clock edge. After release and one edge → `sum`=4'hF, `c_out`=1, `p`=0.
- Zero/max operands:
  - `a`=0, `b`=0, `c_in`=0, one edge → `sum`=0, `c_out`=0, `p`=0.
  - Then `a`=4'hF, `b`=4'hF, `c_in`=0 → next cycle `sum`=4'hE, `c_out`=1, `p`=0.
- Skip path:
  - `a`=4'hF, `b`=4'h0, `c_in`=1 → `sum`=4'h0, `c_out`=1, `p`=1.
  - `a`=4'h5, `b`=4'hA, `c_in`=0 → `sum`=4'hF, `c_out`=0, `p`=1.
- Latency: change inputs every cycle through (3,4,0)→(7,9,1)→(8,8,0). Outputs trail by exactly one cycle: {`c_out`,`sum`} = 7, 17, 16.
- Mid-operation reset: assert `rst_n` low between edges while outputs are nonzero → outputs drop to 0 immediately. Deassert → normal capture resumes on the next edge.
- Exhaustive: all 512 combinations of `a`, `b`, `c_in`, each checked one cycle later against `a`+`b`+`c_in` and the XOR-AND propagate reference.
